osc_freq_meter: RTL and testbench

// - Measures ring-oscillator frequency in the clk domain, downstream of ring_worker's oscdiv outputs.
// - Counts rising edges of an asynchronous oscillator tap over a gate of N whole VGA frames, timed by frame_tick.
// - Latches each result for readout, and drives a registered horizontal bar-graph pixel for the RGB overlay.

---
 rtl/osc_freq_meter.sv | 116 +++++++++++
 tb/tb_osc_freq_meter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/osc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronized osc_in rising edges over N_FRAMES frames.
// meas/meas_valid update on the gate-closing tick edge; bar_px is 1 clk behind hpos/visible. No backpressure.
module osc_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int N_FRAMES    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int BAR_SHIFT   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ena,
    input  logic             osc_in,
    input  logic             frame_tick,
    input  logic [9:0]       hpos,
    input  logic             visible,
    output logic [CNT_W-1:0] meas,
    output logic             meas_valid,
    output logic             meas_ovf,
    output logic             bar_px
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, GATING = 2'd2} state_t;

    localparam logic [7:0] LAST_FRAME = 8'(N_FRAMES - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   edge_p;
    logic [CNT_W-1:0]       cnt;
    logic [7:0]             frames;
    logic                   ovf_run;

    logic                   cnt_max;
    logic                   edge_at_max;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   gate_end;
    logic [CNT_W-1:0]       bar_len;
    logic                   bar_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            sync_d <= 1'b0;
            edge_p <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            sync_d <= sync_q[SYNC_STAGES-1];
            edge_p <= sync_q[SYNC_STAGES-1] & ~sync_d;
        end
    end

    assign cnt_max     = &cnt;
    assign edge_at_max = edge_p & cnt_max;
    assign cnt_inc     = (edge_p && !cnt_max) ? cnt + CNT_W'(1) : cnt;
    assign gate_end    = frame_tick && (frames == LAST_FRAME);

    // hpos < min(len, 1023) reduces to hpos < len with hpos == 1023 excluded.
    assign bar_len = meas >> BAR_SHIFT;
    assign bar_hit = (hpos != 10'h3FF) && ({{CNT_W{1'b0}}, hpos} < {10'b0, bar_len});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            frames     <= '0;
            ovf_run    <= 1'b0;
            meas       <= '0;
            meas_valid <= 1'b0;
            meas_ovf   <= 1'b0;
            bar_px     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            bar_px     <= visible && bar_hit;
            if (!ena) begin
                state   <= IDLE;
                cnt     <= '0;
                frames  <= '0;
                ovf_run <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ARMED;
                    end
                    ARMED: begin
                        if (frame_tick) begin
                            state   <= GATING;
                            cnt     <= '0;
                            frames  <= '0;
                            ovf_run <= 1'b0;
                        end
                    end
                    GATING: begin
                        // An edge landing on the closing tick still belongs to the closing gate.
                        if (gate_end) begin
                            meas       <= cnt_inc;
                            meas_ovf   <= ovf_run | edge_at_max;
                            meas_valid <= 1'b1;
                            cnt        <= '0;
                            frames     <= '0;
                            ovf_run    <= 1'b0;
                        end else begin
                            cnt     <= cnt_inc;
                            ovf_run <= ovf_run | edge_at_max;
                            if (frame_tick) begin
                                frames <= frames + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_osc_freq_meter.sv
// Bench for osc_freq_meter: randomized oscillator/frame/ena stimulus against a count-based reference model.
module tb_osc_freq_meter;
    localparam int CNT_W    = 8;
    localparam int N_FRAMES = 2;
    localparam int SYNC     = 3;
    localparam int BSH      = 2;
    localparam int MAXV     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             osc_in = 1'b0;
    logic             frame_tick = 1'b0;
    logic [9:0]       hpos = '0;
    logic             visible = 1'b0;
    logic [CNT_W-1:0] meas;
    logic             meas_valid;
    logic             meas_ovf;
    logic             bar_px;

    always #5 clk = ~clk;

    osc_freq_meter #(
        .CNT_W(CNT_W), .N_FRAMES(N_FRAMES), .SYNC_STAGES(SYNC), .BAR_SHIFT(BSH)
    ) dut (
        .clk(clk), .reset(rst), .ena(ena), .osc_in(osc_in), .frame_tick(frame_tick),
        .hpos(hpos), .visible(visible), .meas(meas), .meas_valid(meas_valid),
        .meas_ovf(meas_ovf), .bar_px(bar_px)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus generator: square or random-duty oscillator, frame ticks every fp cycles.
    int osc_half = 4;
    int osc_len  = 4;
    int osc_ctr  = 0;
    int fp       = 400;
    int tick_ctr = 0;
    bit osc_rand = 1'b0;
    bit fp_rand  = 1'b0;

    always @(posedge clk) begin
        #1;
        osc_ctr++;
        if (osc_ctr >= (osc_rand ? osc_len : osc_half)) begin
            osc_in  = ~osc_in;
            osc_ctr = 0;
            osc_len = $urandom_range(2, 7);
        end
        tick_ctr++;
        if (tick_ctr >= fp) begin
            frame_tick = 1'b1;
            tick_ctr   = 0;
            if (fp_rand) fp = $urandom_range(300, 500);
        end else begin
            frame_tick = 1'b0;
        end
        hpos    = 10'($urandom_range(0, 70));
        visible = ($urandom_range(0, 3) != 0);
    end

    // Reference model: edges are rises of the sampled osc_in seen SYNC+1 clocks late;
    // a gate is N_FRAMES ticks long and its result is the saturated total edge count.
    bit hist[$];
    int mode = 0;          // 0 idle, 1 waiting for first tick, 2 gate open
    int edges = 0;
    int ticks = 0;
    int tick_seen = 0;
    int exp_meas = 0;
    bit exp_valid = 1'b0;
    bit exp_ovf = 1'b0;
    bit exp_bar = 1'b0;
    int hp_s = 0;
    bit vis_s = 1'b0;
    bit e_now;
    int bar_lim;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist = {};
            for (int i = 0; i < SYNC + 3; i++) hist.push_front(1'b0);
            mode = 0; edges = 0; ticks = 0;
            exp_meas = 0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_bar = 1'b0;
        end else begin
            hist.push_front(osc_in);
            void'(hist.pop_back());
            e_now = hist[SYNC+1] && !hist[SYNC+2];
            hp_s  = int'(hpos);
            vis_s = visible;
            bar_lim = exp_meas >> BSH;
            if (bar_lim > 1023) bar_lim = 1023;
            exp_bar   = visible && (hp_s < bar_lim);
            exp_valid = 1'b0;
            if (frame_tick) tick_seen++;
            if (!ena) begin
                mode = 0; edges = 0; ticks = 0;
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1) begin
                if (frame_tick) begin
                    mode = 2; edges = 0; ticks = 0;
                end
            end else begin
                edges += int'(e_now);
                if (frame_tick) begin
                    ticks++;
                    if (ticks == N_FRAMES) begin
                        exp_meas  = (edges > MAXV) ? MAXV : edges;
                        exp_ovf   = (edges > MAXV);
                        exp_valid = 1'b1;
                        edges = 0;
                        ticks = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("meas", int'(meas), exp_meas);
            check("meas_valid", int'(meas_valid), int'(exp_valid));
            check("meas_ovf", int'(meas_ovf), int'(exp_ovf));
            check("bar_px", int'(bar_px), int'(exp_bar));
        end
    end

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (meas_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL valid_timeout: no meas_valid within %0d cycles, required one", budget);
        end
    endtask

    // Second result after a parameter change comes from a gate fully under the new settings.
    task automatic run_phase(input string name, input int half, input int period,
                             input int em, input int eo);
        bit ok;
        osc_rand = 1'b0;
        fp_rand  = 1'b0;
        osc_half = half;
        fp       = period;
        wait_valid(4000, ok);
        wait_valid(4000, ok);
        check({name, "_meas"}, int'(meas), em);
        check({name, "_ovf"}, int'(meas_ovf), eo);
    endtask

    initial begin
        bit ok;
        int nv;
        int t0;
        repeat (3) @(negedge clk);
        check("rst_meas", int'(meas), 0);
        check("rst_valid", int'(meas_valid), 0);
        check("rst_ovf", int'(meas_ovf), 0);
        check("rst_bar", int'(bar_px), 0);
        rst = 1'b0;
        ena = 1'b1;

        // clk/8 over an 800-cycle gate -> 100 edges.
        run_phase("basic", 4, 400, 100, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bar_lit", int'(bar_px), int'(vis_s && (hp_s < 25)));
        end

        // Drop ena mid-gate: nothing reported, old meas kept, restart needs arm + full gate.
        wait_valid(4000, ok);
        repeat (450) @(negedge clk);
        ena = 1'b0;
        nv = 0;
        repeat (100) begin
            @(negedge clk);
            if (meas_valid) nv++;
        end
        check("drop_no_valid", nv, 0);
        check("drop_meas_held", int'(meas), 100);
        t0  = tick_seen;
        ena = 1'b1;
        wait_valid(4000, ok);
        check("rearm_ticks", tick_seen - t0, 3);
        check("rearm_meas", int'(meas), 100);

        // clk/4 over 1200 cycles -> 300 edges saturates at 255; clk/8 -> 150.
        run_phase("sat", 2, 600, MAXV, 1);
        run_phase("unsat", 4, 600, 150, 0);

        osc_rand = 1'b1;
        fp_rand  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(300, 2500)) @(negedge clk);
            ena = ~ena;
        end
        @(negedge clk);
        ena = 1'b1;

        run_phase("restore", 4, 400, 100, 0);
        repeat (300) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_meas", int'(meas), 0);
        check("mid_rst_valid", int'(meas_valid), 0);
        check("mid_rst_ovf", int'(meas_ovf), 0);
        check("mid_rst_bar", int'(bar_px), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_valid(4000, ok);
        check("post_rst_meas", int'(meas), 100);
        check("post_rst_ovf", int'(meas_ovf), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
